// File: rtl/decode_pipe.sv
// Instruction-decode stage: register file with write-back bypass, immediate
// generation and an ID/EX output register with an optional load-use interlock.
module decode_pipe #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter bit HAZ_EN   = 1'b1
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              In_valid,
    output logic              In_ready,
    input  logic [31:0]       Instr,
    input  logic              RF_B_sel,
    input  logic              RF_WrEn,
    input  logic [4:0]        RF_Awr,
    input  logic [DATA_W-1:0] RF_WrData,
    output logic              Out_valid,
    input  logic              Out_ready,
    output logic [DATA_W-1:0] RF_A,
    output logic [DATA_W-1:0] RF_B,
    output logic [DATA_W-1:0] Immed,
    output logic [4:0]        Awr_out,
    output logic [5:0]        Opcode_out,
    output logic              Is_load
);

    localparam int         AW    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [5:0] NREGS = 6'(NUM_REGS);

    logic [DATA_W-1:0] regs [NUM_REGS];

    logic [5:0]        opcode;
    logic [15:0]       imm;
    logic [4:0]        addr_a;
    logic [4:0]        addr_b;
    logic              a_in_range;
    logic              b_in_range;
    logic              wr_fire;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic [DATA_W-1:0] sext;
    logic [DATA_W-1:0] immed_d;
    logic              is_load_d;
    logic              hazard;
    logic              accept;

    assign opcode = Instr[31:26];
    assign imm    = Instr[15:0];
    assign addr_a = Instr[25:21];
    assign addr_b = RF_B_sel ? Instr[20:16] : Instr[15:11];

    // R0 and addresses beyond the implemented file are never stored or read.
    assign a_in_range = (addr_a != 5'd0) && ({1'b0, addr_a} < NREGS);
    assign b_in_range = (addr_b != 5'd0) && ({1'b0, addr_b} < NREGS);
    assign wr_fire    = RF_WrEn && (RF_Awr != 5'd0) && ({1'b0, RF_Awr} < NREGS);

    always_comb begin
        rd_a = '0;
        rd_b = '0;
        if (a_in_range) begin
            if (RF_WrEn && (RF_Awr == addr_a)) rd_a = RF_WrData;
            else                               rd_a = regs[addr_a[AW-1:0]];
        end
        if (b_in_range) begin
            if (RF_WrEn && (RF_Awr == addr_b)) rd_b = RF_WrData;
            else                               rd_b = regs[addr_b[AW-1:0]];
        end
    end

    assign sext = {{(DATA_W-16){imm[15]}}, imm};

    always_comb begin
        immed_d = '0;
        case (opcode)
            6'b111000, 6'b110000, 6'b000011,
            6'b000111, 6'b001111, 6'b011111: immed_d = sext;
            6'b110010, 6'b110011:            immed_d = DATA_W'(imm);
            6'b111111, 6'b000000, 6'b000001: immed_d = sext << 2;
            6'b111001:                       immed_d = DATA_W'({imm, 16'h0000});
            default:                         immed_d = '0;
        endcase
    end

    assign is_load_d = (opcode == 6'b000011) || (opcode == 6'b001111);

    // Handshake: an instruction transfers on an edge where In_valid && In_ready;
    // the output transfers where Out_valid && Out_ready. In_ready is withheld
    // while a registered load writes a register the offered instruction reads.
    always_comb begin
        hazard = 1'b0;
        if (HAZ_EN) begin
            hazard = Out_valid && Is_load && (Awr_out != 5'd0) &&
                     ((Awr_out == addr_a) || (Awr_out == addr_b));
        end
        In_ready = !Reset_n || (!hazard && (!Out_valid || Out_ready));
    end

    assign accept = In_valid && In_ready;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wr_fire) begin
            regs[RF_Awr[AW-1:0]] <= RF_WrData;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            Out_valid  <= 1'b0;
            RF_A       <= '0;
            RF_B       <= '0;
            Immed      <= '0;
            Awr_out    <= '0;
            Opcode_out <= '0;
            Is_load    <= 1'b0;
        end else if (accept) begin
            Out_valid  <= 1'b1;
            RF_A       <= rd_a;
            RF_B       <= rd_b;
            Immed      <= immed_d;
            Awr_out    <= Instr[20:16];
            Opcode_out <= opcode;
            Is_load    <= is_load_d;
        end else if (Out_ready) begin
            Out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_pipe.sv
// Self-checking bench for decode_pipe: directed scenarios plus randomized
// traffic compared against a behavioural model of the decode stage.
module tb_decode_pipe;

    localparam int PW = 32 * 3 + 5 + 6 + 1;

    logic        Clk;
    logic        Reset_n;
    logic        In_valid;
    logic        In_ready;
    logic [31:0] Instr;
    logic        RF_B_sel;
    logic        RF_WrEn;
    logic [4:0]  RF_Awr;
    logic [31:0] RF_WrData;
    logic        Out_valid;
    logic        Out_ready;
    logic [31:0] RF_A, RF_B, Immed;
    logic [4:0]  Awr_out;
    logic [5:0]  Opcode_out;
    logic        Is_load;

    logic        In_ready_nh, Out_valid_nh, Is_load_nh;
    logic [31:0] RF_A_nh, RF_B_nh, Immed_nh;
    logic [4:0]  Awr_out_nh;
    logic [5:0]  Opcode_out_nh;

    int total = 0;
    int bad   = 0;

    // model of the stage
    logic [31:0] ref_rf [32];
    logic        m_valid, m_load;
    logic [31:0] m_a, m_b, m_imm;
    logic [4:0]  m_awr;
    logic [5:0]  m_op;
    logic [PW-1:0] exp_q[$];

    logic obs_rdy, obs_rdy_nh, exp_rdy, exp_acc;
    logic [PW-1:0] dut_pack;
    assign dut_pack = {RF_A, RF_B, Immed, Awr_out, Opcode_out, Is_load};

    decode_pipe #(.DATA_W(32), .NUM_REGS(32), .HAZ_EN(1'b1)) u_dut (
        .Clk(Clk), .Reset_n(Reset_n), .In_valid(In_valid), .In_ready(In_ready),
        .Instr(Instr), .RF_B_sel(RF_B_sel), .RF_WrEn(RF_WrEn), .RF_Awr(RF_Awr),
        .RF_WrData(RF_WrData), .Out_valid(Out_valid), .Out_ready(Out_ready),
        .RF_A(RF_A), .RF_B(RF_B), .Immed(Immed), .Awr_out(Awr_out),
        .Opcode_out(Opcode_out), .Is_load(Is_load)
    );

    decode_pipe #(.DATA_W(32), .NUM_REGS(32), .HAZ_EN(1'b0)) u_nohaz (
        .Clk(Clk), .Reset_n(Reset_n), .In_valid(In_valid), .In_ready(In_ready_nh),
        .Instr(Instr), .RF_B_sel(RF_B_sel), .RF_WrEn(RF_WrEn), .RF_Awr(RF_Awr),
        .RF_WrData(RF_WrData), .Out_valid(Out_valid_nh), .Out_ready(Out_ready),
        .RF_A(RF_A_nh), .RF_B(RF_B_nh), .Immed(Immed_nh), .Awr_out(Awr_out_nh),
        .Opcode_out(Opcode_out_nh), .Is_load(Is_load_nh)
    );

    // clock / reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [31:0] ref_imm(input logic [5:0] op, input logic [15:0] im);
        logic [31:0] s;
        s = {{16{im[15]}}, im};
        case (op)
            6'b111000, 6'b110000, 6'b000011, 6'b000111, 6'b001111, 6'b011111: return s;
            6'b110010, 6'b110011: return {16'h0000, im};
            6'b111111, 6'b000000, 6'b000001: return s * 4;
            6'b111001: return {im, 16'h0000};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] addr, input logic we,
                                             input logic [4:0] awr, input logic [31:0] wd);
        if (addr == 5'd0) return 32'h0;
        if (we && awr == addr) return wd;
        return ref_rf[addr];
    endfunction

    function automatic logic instr_is_load(input logic [5:0] op);
        return (op == 6'b000011) || (op == 6'b001111);
    endfunction

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] im);
        return {op, rs, rt, im};
    endfunction

    // driver: apply one cycle of inputs, sample In_ready, advance model and DUT
    task automatic step(input logic v, input logic [31:0] ins, input logic bsel,
                        input logic we, input logic [4:0] awr, input logic [31:0] wd,
                        input logic ordy);
        logic [4:0] rs, rb;
        logic       dep;
        In_valid = v; Instr = ins; RF_B_sel = bsel; RF_WrEn = we;
        RF_Awr = awr; RF_WrData = wd; Out_ready = ordy;
        rs  = ins[25:21];
        rb  = bsel ? ins[20:16] : ins[15:11];
        dep = m_valid && m_load && m_awr != 5'd0 && (m_awr == rs || m_awr == rb);
        exp_rdy = !Reset_n || (!dep && (!m_valid || ordy));
        exp_acc = Reset_n && v && exp_rdy;
        #1;
        obs_rdy    = In_ready;
        obs_rdy_nh = In_ready_nh;
        @(posedge Clk);
        if (!Reset_n) begin
            for (int i = 0; i < 32; i++) ref_rf[i] = 32'h0;
            {m_valid, m_load, m_a, m_b, m_imm, m_awr, m_op} = '0;
        end else begin
            if (exp_acc) begin
                m_valid = 1'b1;
                m_a     = ref_read(rs, we, awr, wd);
                m_b     = ref_read(rb, we, awr, wd);
                m_imm   = ref_imm(ins[31:26], ins[15:0]);
                m_awr   = ins[20:16];
                m_op    = ins[31:26];
                m_load  = instr_is_load(ins[31:26]);
                exp_q.push_back({m_a, m_b, m_imm, m_awr, m_op, m_load});
            end else if (ordy) begin
                m_valid = 1'b0;
            end
            if (we && awr != 5'd0) ref_rf[awr] = wd;
        end
        #1;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        step(1'b1, mk(6'b110000, 5'd1, 5'd2, 16'h1), 1'b1, 1'b1, 5'd4, 32'h99, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        total++;
        if (obs_rdy !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %0b want 1", obs_rdy); end
        total++;
        if (Out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %0b want 0", Out_valid); end
        total++;
        if (dut_pack !== '0) begin bad++; $display("FAIL reset_outputs: got %h want 0", dut_pack); end
        Reset_n = 1'b1;
    endtask

    task automatic test_basic();
        step(1'b0, 32'h0, 1'b0, 1'b1, 5'd5, 32'h0000_1234, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1, 5'd6, 32'hFFFF_0000, 1'b1);
        step(1'b1, mk(6'b110000, 5'd5, 5'd6, 16'h8001), 1'b1, 1'b0, 5'd0, 32'h0, 1'b1);
        total++;
        if (Out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid: got %0b want 1", Out_valid); end
        total++;
        if (RF_A !== 32'h0000_1234) begin bad++; $display("FAIL basic_rf_a: got %h want 00001234", RF_A); end
        total++;
        if (RF_B !== 32'hFFFF_0000) begin bad++; $display("FAIL basic_rf_b: got %h want ffff0000", RF_B); end
        total++;
        if (Immed !== 32'hFFFF_8001) begin bad++; $display("FAIL basic_immed: got %h want ffff8001", Immed); end
        total++;
        if (Awr_out !== 5'd6 || Opcode_out !== 6'b110000) begin
            bad++; $display("FAIL basic_fields: got awr=%0d op=%b want awr=6 op=110000", Awr_out, Opcode_out);
        end
    endtask

    task automatic test_immediate();
        logic [5:0]  ops  [6] = '{6'b110010, 6'b000000, 6'b111001, 6'b101010, 6'b000011, 6'b110011};
        logic [31:0] imms [6] = '{32'h0000_8001, 32'hFFFE_0004, 32'h8001_0000, 32'h0, 32'hFFFF_8001, 32'h0000_8001};
        logic        lds  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            step(1'b1, mk(ops[i], 5'd0, 5'd0, 16'h8001), 1'b1, 1'b0, 5'd0, 32'h0, 1'b1);
            total++;
            if (Immed !== imms[i] || Is_load !== lds[i]) begin
                bad++;
                $display("FAIL imm_op_%b: got imm=%h load=%0b want imm=%h load=%0b",
                         ops[i], Immed, Is_load, imms[i], lds[i]);
            end
        end
    endtask

    task automatic test_bypass();
        step(1'b1, mk(6'b110000, 5'd7, 5'd0, 16'h0), 1'b1, 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b1);
        total++;
        if (RF_A !== 32'hDEAD_BEEF) begin bad++; $display("FAIL bypass_same_cycle: got %h want deadbeef", RF_A); end
        step(1'b1, mk(6'b110000, 5'd7, 5'd0, 16'h0), 1'b1, 1'b0, 5'd0, 32'h0, 1'b1);
        total++;
        if (RF_A !== 32'hDEAD_BEEF) begin bad++; $display("FAIL bypass_array: got %h want deadbeef", RF_A); end
        step(1'b1, mk(6'b110000, 5'd0, 5'd7, 16'h0), 1'b1, 1'b1, 5'd0, 32'h55, 1'b1);
        total++;
        if (RF_A !== 32'h0 || RF_B !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL r0_write_same: got a=%h b=%h want a=0 b=deadbeef", RF_A, RF_B);
        end
        step(1'b1, mk(6'b110000, 5'd0, 5'd0, 16'h0), 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
        total++;
        if (RF_A !== 32'h0 || RF_B !== 32'h0) begin
            bad++; $display("FAIL r0_after_write: got a=%h b=%h want 0 0", RF_A, RF_B);
        end
    endtask

    task automatic test_load_use();
        logic [31:0] ld, dep;
        ld  = mk(6'b001111, 5'd0, 5'd3, 16'h0);
        dep = mk(6'b110000, 5'd3, 5'd0, 16'h0);
        step(1'b1, ld, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1);
        total++;
        if (Is_load !== 1'b1 || Awr_out !== 5'd3) begin
            bad++; $display("FAIL lu_load_reg: got load=%0b awr=%0d want 1 3", Is_load, Awr_out);
        end
        step(1'b1, dep, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1);
        total++;
        if (obs_rdy !== 1'b0) begin bad++; $display("FAIL lu_stall_ready: got %0b want 0", obs_rdy); end
        total++;
        if (obs_rdy_nh !== 1'b1) begin bad++; $display("FAIL lu_nohaz_ready: got %0b want 1", obs_rdy_nh); end
        total++;
        if (Out_valid !== 1'b0) begin bad++; $display("FAIL lu_bubble: got %0b want 0", Out_valid); end
        total++;
        if (Out_valid_nh !== 1'b1 || Opcode_out_nh !== 6'b110000) begin
            bad++; $display("FAIL lu_nohaz_no_bubble: got v=%0b op=%b want 1 110000", Out_valid_nh, Opcode_out_nh);
        end
        step(1'b1, dep, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1);
        total++;
        if (obs_rdy !== 1'b1 || Out_valid !== 1'b1 || Opcode_out !== 6'b110000) begin
            bad++; $display("FAIL lu_accept_after: got rdy=%0b v=%0b op=%b want 1 1 110000",
                            obs_rdy, Out_valid, Opcode_out);
        end
        // dependent instruction waiting behind a stalled load
        step(1'b1, ld, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, dep, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
            total++;
            if (obs_rdy !== 1'b0 || Out_valid !== 1'b1 || Is_load !== 1'b1) begin
                bad++; $display("FAIL lu_hold_%0d: got rdy=%0b v=%0b load=%0b want 0 1 1",
                                i, obs_rdy, Out_valid, Is_load);
            end
        end
        step(1'b1, dep, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1);
        total++;
        if (obs_rdy !== 1'b0 || Out_valid !== 1'b0) begin
            bad++; $display("FAIL lu_release_bubble: got rdy=%0b v=%0b want 0 0", obs_rdy, Out_valid);
        end
        step(1'b1, dep, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1);
        total++;
        if (obs_rdy !== 1'b1 || Out_valid !== 1'b1) begin
            bad++; $display("FAIL lu_release_accept: got rdy=%0b v=%0b want 1 1", obs_rdy, Out_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] x, y;
        x = mk(6'b110000, 5'd5, 5'd6, 16'h0011);
        y = mk(6'b111001, 5'd6, 5'd5, 16'h00AB);
        step(1'b1, x, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, y, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
            total++;
            if (obs_rdy !== 1'b0 || Out_valid !== 1'b1 || RF_A !== 32'h0000_1234 ||
                Immed !== 32'h0000_0011 || Opcode_out !== 6'b110000) begin
                bad++; $display("FAIL bp_hold_%0d: got rdy=%0b v=%0b a=%h imm=%h op=%b want 0 1 00001234 00000011 110000",
                                i, obs_rdy, Out_valid, RF_A, Immed, Opcode_out);
            end
        end
        step(1'b1, y, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1);
        total++;
        if (obs_rdy !== 1'b1 || RF_A !== 32'hFFFF_0000 || RF_B !== 32'h0000_1234 ||
            Immed !== 32'h00AB_0000) begin
            bad++; $display("FAIL bp_release: got rdy=%0b a=%h b=%h imm=%h want 1 ffff0000 00001234 00ab0000",
                            obs_rdy, RF_A, RF_B, Immed);
        end
    endtask

    task automatic test_random();
        logic [5:0]  ops [12] = '{6'b111000, 6'b110000, 6'b000011, 6'b000111, 6'b001111, 6'b011111,
                                  6'b110010, 6'b110011, 6'b111111, 6'b000000, 6'b000001, 6'b111001};
        logic [5:0]    op;
        logic [31:0]   ins;
        logic [4:0]    awr;
        logic [PW-1:0] exp;
        exp_q.delete();
        for (int n = 0; n < 400; n++) begin
            op  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : ops[$urandom_range(0, 11)];
            ins = mk(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom));
            if ($urandom_range(0, 1) == 1) ins[15:11] = 5'($urandom_range(0, 7));
            awr = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            step($urandom_range(0, 4) != 0, ins, 1'($urandom), 1'($urandom), awr,
                 $urandom, $urandom_range(0, 9) < 7);
            total++;
            if (obs_rdy !== exp_rdy) begin
                bad++; $display("FAIL rnd_ready_%0d: got %0b want %0b", n, obs_rdy, exp_rdy);
            end
            total++;
            if (Out_valid !== m_valid) begin
                bad++; $display("FAIL rnd_valid_%0d: got %0b want %0b", n, Out_valid, m_valid);
            end
            if (exp_acc && exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                total++;
                if (dut_pack !== exp) begin
                    bad++; $display("FAIL rnd_data_%0d: got %h want %h", n, dut_pack, exp);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        step(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
        step(1'b1, mk(6'b110000, 5'd1, 5'd2, 16'h7), 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
        total++;
        if (Out_valid !== 1'b1) begin bad++; $display("FAIL rm_pre_valid: got %0b want 1", Out_valid); end
        Reset_n = 1'b0;
        step(1'b1, mk(6'b110000, 5'd1, 5'd2, 16'h7), 1'b1, 1'b1, 5'd9, 32'h1234_5678, 1'b0);
        total++;
        if (obs_rdy !== 1'b1) begin bad++; $display("FAIL rm_ready_in_reset: got %0b want 1", obs_rdy); end
        total++;
        if (Out_valid !== 1'b0 || dut_pack !== '0) begin
            bad++; $display("FAIL rm_outputs: got v=%0b data=%h want 0 0", Out_valid, dut_pack);
        end
        Reset_n = 1'b1;
        for (int i = 1; i < 32; i++) begin
            step(1'b1, mk(6'b110000, 5'(i), 5'(i), 16'h0), 1'b1, 1'b0, 5'd0, 32'h0, 1'b1);
            total++;
            if (RF_A !== 32'h0 || RF_B !== 32'h0) begin
                bad++; $display("FAIL rm_reg_%0d: got a=%h b=%h want 0 0", i, RF_A, RF_B);
            end
        end
    endtask

    initial begin
        Reset_n = 1'b0; In_valid = 1'b0; Instr = '0; RF_B_sel = 1'b0;
        RF_WrEn = 1'b0; RF_Awr = '0; RF_WrData = '0; Out_ready = 1'b0;
        for (int i = 0; i < 32; i++) ref_rf[i] = 32'h0;
        {m_valid, m_load, m_a, m_b, m_imm, m_awr, m_op} = '0;
        test_reset();
        test_basic();
        test_immediate();
        test_bypass();
        test_load_use();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
